router_1xn_pkt: RTL and testbench

//  Parametrised 1-to-N packet router, the successor to the fixed 1x3 router.
//  - Accepts byte-serial packets: header {len,addr}, payload bytes, trailing parity byte.
//  - Steers each packet into one of NCH per-channel FIFOs, with DW-wide data.
//  - New over 1x3: header address range check, payload-length check, per-channel

---
 rtl/router_1xn_pkt.sv | 191 +++++++++++++++++++
 tb/tb_router_1xn_pkt.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1xn_pkt.sv
// router_1xn_pkt: header-steered byte-serial packet router into NCH
// channel FIFOs with parity, length, address and read-timeout checks.
module router_1xn_pkt #(
  parameter int DW      = 8,
  parameter int NCH     = 3,
  parameter int ADDR_W  = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DW-1:0]     data_in,
  output logic              busy,
  input  logic [NCH-1:0]    read_enb,
  output logic [NCH-1:0]    valid_out,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    soft_reset,
  output logic              error,
  output logic              len_err,
  output logic              addr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = DW - ADDR_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NA = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NCH_L =
    (ADDR_W + 1)'(NCH);

  typedef enum logic [1:0] {
    IDLE, LOAD, CHECK, DROP
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] hdr_addr, dest, wr_ch;
  logic [LW-1:0]     hdr_len, len_q, cnt;
  logic [DW-1:0]     parity, rx_par;
  logic [NCH-1:0]    full;
  logic [NA-1:0]     full_ext;
  logic              addr_ok, busy_c, wr_en;
  logic              ld_hdr, ld_byte, ld_par;
  logic              do_chk, bad_addr;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DW-1:ADDR_W];
  assign addr_ok  = {1'b0, hdr_addr} < NCH_L;
  assign full_ext = NA'(full);
  assign busy     = busy_c & ~reset;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    busy_c   = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = dest;
    ld_hdr   = 1'b0;
    ld_byte  = 1'b0;
    ld_par   = 1'b0;
    do_chk   = 1'b0;
    bad_addr = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (!addr_ok) begin
            bad_addr = 1'b1;
            nxt      = DROP;
          end else if (full_ext[hdr_addr]) begin
            busy_c = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_ch  = hdr_addr;
            ld_hdr = 1'b1;
            nxt    = LOAD;
          end
        end
      end
      LOAD: begin
        if (full_ext[dest]) begin
          busy_c = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (pkt_valid) begin
            ld_byte = 1'b1;
          end else begin
            ld_par = 1'b1;
            nxt    = CHECK;
          end
        end
      end
      CHECK: begin
        busy_c = 1'b1;
        do_chk = 1'b1;
        nxt    = IDLE;
      end
      DROP: begin
        if (!pkt_valid) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dest     <= '0;
      len_q    <= '0;
      cnt      <= '0;
      parity   <= '0;
      rx_par   <= '0;
      error    <= 1'b0;
      len_err  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= bad_addr;
      if (ld_hdr) begin
        dest    <= hdr_addr;
        len_q   <= hdr_len;
        cnt     <= '0;
        parity  <= data_in;
        error   <= 1'b0;
        len_err <= 1'b0;
      end
      if (ld_byte) begin
        parity <= parity ^ data_in;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
      if (ld_par) rx_par <= data_in;
      if (do_chk) begin
        error   <= parity != rx_par;
        len_err <= cnt != len_q;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] fill;
    logic [TW-1:0] tmr;
    logic [DW-1:0] dq;
    logic          sr, wr, rd, idle, flush;

    assign full[i]      = fill == CW'(DEPTH);
    assign valid_out[i] = fill != '0;
    assign wr    = wr_en && (wr_ch == ADDR_W'(i));
    assign rd    = read_enb[i] && valid_out[i];
    assign idle  = valid_out[i] && !read_enb[i];
    assign flush = idle && (tmr == TW'(TIMEOUT - 1));

    // a timeout flush wins over any write landing the same edge
    always_ff @(posedge clock) begin
      if (reset) begin
        wp   <= '0;
        rp   <= '0;
        fill <= '0;
        tmr  <= '0;
        dq   <= '0;
        sr   <= 1'b0;
      end else begin
        sr <= flush;
        if (flush) begin
          wp   <= '0;
          rp   <= '0;
          fill <= '0;
          tmr  <= '0;
        end else begin
          tmr <= idle ? tmr + 1'b1 : '0;
          if (wr) wp <= wp + 1'b1;
          if (rd) begin
            dq <= mem[rp];
            rp <= rp + 1'b1;
          end
          fill <= fill + CW'(wr) - CW'(rd);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (wr && !flush) mem[wp] <= data_in;
    end

    assign data_out[i*DW +: DW] = dq;
    assign soft_reset[i]        = sr;
  end

endmodule

// File: tb/tb_router_1xn_pkt.sv
// tb_router_1xn_pkt: vector table, directed corner sequences and random
// packets scored against per-channel byte queues.
module tb_router_1xn_pkt;

  localparam int NCH = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [2:0]  read_enb = 3'b000;
  logic        busy, error, len_err, addr_err;
  logic [2:0]  valid_out, soft_reset;
  logic [23:0] data_out;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rd_mode = 1'b0;
  logic [7:0] q [NCH][$];

  typedef struct {
    logic [7:0] hdr;
    int         npay;
    logic [7:0] pxor;
    logic       e_err;
    logic       e_len;
    logic       e_aerr;
  } vec_t;

  vec_t tbl [12];

  router_1xn_pkt dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .busy       (busy),
    .read_enb   (read_enb),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .soft_reset (soft_reset),
    .error      (error),
    .len_err    (len_err),
    .addr_err   (addr_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // reader + scoreboard: every pop must return the oldest expected byte
  initial begin : mon
    logic [2:0] rd_mask;
    logic [7:0] exp;
    int gap [NCH];
    foreach (gap[i]) gap[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NCH; i++) begin
        if (!rd_mode || reset) begin
          read_enb[i] = 1'b0;
          gap[i] = 0;
        end else begin
          read_enb[i] = (gap[i] >= 3) ? 1'b1 :
                        1'($urandom_range(0, 1));
          gap[i] = read_enb[i] ? 0 : gap[i] + 1;
        end
      end
      rd_mask = read_enb & valid_out;
      @(posedge clock);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (rd_mask[i]) begin
          n_chk++;
          if (q[i].size() == 0) begin
            n_fail++;
            $display("FAIL pop_ch%0d: got %0h, expected no byte",
                     i, data_out[i*8 +: 8]);
          end else begin
            exp = q[i].pop_front();
            if (data_out[i*8 +: 8] !== exp) begin
              n_fail++;
              $display("FAIL pop_ch%0d: got %0h, expected %0h",
                       i, data_out[i*8 +: 8], exp);
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic v, input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    pkt_valid = v;
    data_in   = d;
    #1;
    while (busy && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_byte: busy got 1, expected 0 in 200 cycles");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int npay,
                          input logic [7:0] pxor, input bit push,
                          output bit ae, output bit ae2,
                          output logic [7:0] calc,
                          output logic [7:0] sent);
    logic [7:0] b [$];
    logic [1:0] a;
    b.push_back(hdr);
    for (int k = 0; k < npay; k++) b.push_back(8'($urandom));
    calc = 8'h00;
    foreach (b[k]) calc ^= b[k];
    sent = calc ^ pxor;
    b.push_back(sent);
    a = hdr[1:0];
    if (push && a < 2'd3)
      foreach (b[k]) q[a].push_back(b[k]);
    ae  = 1'b0;
    ae2 = 1'b0;
    foreach (b[k]) begin
      send_byte(k != b.size() - 1, b[k]);
      if (k == 0) ae = addr_err;
      if (k == 1) ae2 = addr_err;
    end
    @(negedge clock);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    rd_mode = 1'b1;
    while ((q[0].size() + q[1].size() + q[2].size() != 0 ||
            valid_out != 3'b000) && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_left", q[0].size() + q[1].size() + q[2].size(), 0);
    chk("drain_valid_out", valid_out, 3'b000);
  endtask

  task automatic do_reset();
    rd_mode = 1'b0;
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    pkt_valid = 1'b1;
    data_in   = 8'h3A;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("rst_busy", busy, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_soft_reset", soft_reset, 0);
    chk("rst_error", error, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_addr_err", addr_err, 0);
    @(negedge clock);
    reset     = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    foreach (q[i]) q[i].delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ae, ae2, m_err, m_len;
    logic [7:0] calc, sent, hdr, pxor, par, b0;
    logic [7:0] pay [20];
    int a, len, npay, r, hc;

    tbl[0]  = '{8'h3A, 14, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h3A, 14, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8'h15,  7, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8'h0B,  2, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{8'h08,  2, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h05,  0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{8'h01,  0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h0F,  3, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h12,  4, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{8'h26,  3, 8'h01, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8'h1F,  5, 8'h55, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{8'h44, 17, 8'h00, 1'b0, 1'b0, 1'b0};

    do_reset();

    rd_mode = 1'b1;
    foreach (tbl[i]) begin
      send_pkt(tbl[i].hdr, tbl[i].npay, tbl[i].pxor, 1'b1,
               ae, ae2, calc, sent);
      chk($sformatf("vec%0d_addr_err", i), ae, tbl[i].e_aerr);
      if (tbl[i].e_aerr)
        chk($sformatf("vec%0d_addr_err_fall", i), ae2, 0);
      chk($sformatf("vec%0d_error", i), error, tbl[i].e_err);
      chk($sformatf("vec%0d_len_err", i), len_err, tbl[i].e_len);
    end
    drain();

    // whole 16-byte packet parked in ch2 only
    rd_mode = 1'b0;
    repeat (2) @(negedge clock);
    send_pkt(8'h3A, 14, 8'h00, 1'b1, ae, ae2, calc, sent);
    chk("t1_valid_out", valid_out, 3'b100);
    chk("t1_error", error, 0);
    chk("t1_len_err", len_err, 0);
    drain();

    // 22-byte packet against a 16-deep FIFO with reads held off
    rd_mode = 1'b0;
    repeat (2) @(negedge clock);
    par = 8'h52;
    foreach (pay[k]) begin
      pay[k] = 8'($urandom);
      par ^= pay[k];
    end
    q[2].push_back(8'h52);
    foreach (pay[k]) q[2].push_back(pay[k]);
    q[2].push_back(par);
    send_byte(1'b1, 8'h52);
    for (int k = 0; k < 15; k++) send_byte(1'b1, pay[k]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      pkt_valid = 1'b1;
      data_in   = pay[15];
      #1;
      chk($sformatf("bp_busy%0d", k), busy, 1);
    end
    chk("bp_valid_out", valid_out, 3'b100);
    rd_mode = 1'b1;
    for (int k = 15; k < 20; k++) send_byte(1'b1, pay[k]);
    send_byte(1'b0, par);
    @(negedge clock);
    pkt_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("bp_error", error, 0);
    chk("bp_len_err", len_err, 0);
    drain();

    // unread ch0 is flushed on the 30th idle cycle
    rd_mode = 1'b0;
    repeat (2) @(negedge clock);
    b0 = 8'($urandom);
    send_byte(1'b1, 8'h04);
    hc = cyc;
    chk("to_valid_rise", valid_out, 3'b001);
    send_byte(1'b1, b0);
    send_byte(1'b0, 8'h04 ^ b0);
    @(negedge clock);
    pkt_valid = 1'b0;
    wait_to(hc + 29);
    chk("to_pre_valid", valid_out, 3'b001);
    chk("to_pre_sr", soft_reset, 0);
    wait_to(hc + 30);
    chk("to_valid_out", valid_out, 3'b000);
    chk("to_sr_pulse", soft_reset, 3'b001);
    wait_to(hc + 31);
    chk("to_sr_end", soft_reset, 0);
    chk("to_error", error, 0);
    chk("to_len_err", len_err, 0);
    drain();

    // reset mid-packet, next byte must be a fresh header
    rd_mode = 1'b0;
    repeat (2) @(negedge clock);
    send_byte(1'b1, 8'h3A);
    for (int k = 0; k < 3; k++) send_byte(1'b1, 8'($urandom));
    do_reset();
    rd_mode = 1'b1;
    send_pkt(8'h09, 2, 8'h00, 1'b1, ae, ae2, calc, sent);
    chk("mr_addr_err", ae, 0);
    chk("mr_error", error, 0);
    chk("mr_len_err", len_err, 0);
    drain();

    m_err = 1'b0;
    m_len = 1'b0;
    for (int p = 0; p < 40; p++) begin
      a    = $urandom_range(0, 3);
      len  = $urandom_range(0, 12);
      r    = $urandom_range(0, 9);
      npay = (r == 0) ? len + 1 :
             (r == 1 && len > 0) ? len - 1 : len;
      pxor = ($urandom_range(0, 4) == 0) ?
             8'($urandom_range(1, 255)) : 8'h00;
      hdr  = {6'(len), 2'(a)};
      send_pkt(hdr, npay, pxor, 1'b1, ae, ae2, calc, sent);
      if (a < NCH) begin
        m_err = calc != sent;
        m_len = npay != len;
      end
      chk($sformatf("rnd%0d_addr_err", p), ae, a >= NCH);
      chk($sformatf("rnd%0d_error", p), error, m_err);
      chk($sformatf("rnd%0d_len_err", p), len_err, m_len);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
